puck_motion_ctl: RTL and testbench
==================================

Name: puck_motion_ctl

Overview:
- Per-frame puck physics stage sitting directly upstream of the puck draw stage; produces the puck centre coordinates that stage consumes.
- On every frame tick (rising edge of vblnk_in) it resolves player-mallet hits, advances position by velocity, reflects off side walls and applies friction.
- Detects goals in the top and bottom walls, pulses the matching goal flag, then re-serves the puck from centre after a hold-off.

Parameters:
- X_MIN, 20, left wall inner x
- X_MAX, 748, right wall inner x
- Y_MIN, 20, top wall inner y
- Y_MAX, 1004, bottom wall inner y
- X_CENTRE, 384, serve x
- Y_CENTRE, 512, serve y
- GOAL_X_LO, 284, goal mouth left edge (inclusive)
- GOAL_X_HI, 484, goal mouth right edge (inclusive)
- RADIUS, 10, puck radius in pixels
- HIT_SPEED, 8, per-axis speed magnitude after a mallet hit
- MAX_SPEED, 15, velocity saturation magnitude per axis
- FRICTION_FRAMES, 8, frames between friction decrements
- RESPAWN_FRAMES, 60, frames held after a goal

Ports:
- clk_in  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- vblnk_in  input  1  vertical blank from timing chain; its rising edge is the frame tick
- start  input  1  level; serve the puck from IDLE
- p1_xpos  input  12  player 1 mallet centre x
- p1_ypos  input  12  player 1 mallet centre y
- p2_xpos  input  12  player 2 mallet centre x
- p2_ypos  input  12  player 2 mallet centre y
- radius_player  input  8  mallet radius
- xpos_ball  output  12  puck centre x, registered
- ypos_ball  output  12  puck centre y, registered
- goal_top  output  1  one-cycle pulse, puck entered top goal
- goal_bottom  output  1  one-cycle pulse, puck entered bottom goal
- in_play  output  1  high in FRAME_WAIT/HIT/MOVE

Behaviour:
- Reset values (async, rst_n low):
  - xpos_ball=384, ypos_ball=512
  - vx=vy=0; goal pulses 0; in_play 0
  - friction and respawn counters 0; state IDLE; vblnk edge register 0
- Frame tick: registered vblnk_in delayed one cycle; tick = vblnk_in & ~vblnk_d.
- States:
  - IDLE: puck held at centre. If start=1 on a tick, go to FRAME_WAIT with vx=vy=0.
  - FRAME_WAIT: on tick, go to HIT.
  - HIT (1 cycle):
    - dx = xpos_ball - p1_xpos, dy = ypos_ball - p1_ypos (13-bit signed).
    - Hit if dx*dx + dy*dy <= (RADIUS + radius_player)^2. Products are 26-bit unsigned; compare at 27 bits.
    - On hit: vx = HIT_SPEED*sign(dx) and vy = HIT_SPEED*sign(dy), where sign(0)=0. Then reset the friction counter.
    - If player 1 does not hit, test player 2 the same way. If both overlap, player 1 wins.
    - Go to MOVE.
  - MOVE (1 cycle):
    - nx = x + vx, ny = y + vy, computed signed 14-bit.
    - x axis:
      - nx < X_MIN+RADIUS: x = X_MIN+RADIUS, vx = -vx.
      - nx > X_MAX-RADIUS: x = X_MAX-RADIUS, vx = -vx.
      - otherwise x = nx.
    - y axis:
      - ny < Y_MIN+RADIUS and nx (after x clamp) within [GOAL_X_LO, GOAL_X_HI]: goal_top pulse, go to GOAL_HOLD.
      - ny > Y_MAX-RADIUS and in the mouth: goal_bottom pulse, go to GOAL_HOLD.
      - outside the mouth: clamp to the wall and negate vy.
      - Position is not updated on the goal cycle.
    - Friction: counter increments each MOVE. When it reaches FRICTION_FRAMES-1 it wraps to 0, and nonzero vx and vy each step 1 toward 0.
    - Velocities saturate at ±MAX_SPEED (8-bit signed internal).
    - Go to FRAME_WAIT.
  - GOAL_HOLD:
    - Counts ticks to RESPAWN_FRAMES.
    - Then: x,y = centre; vx=vy=0; counter cleared; go to FRAME_WAIT.
    - Ticks during hold are ignored.
- Latency: positions update exactly 2 clk_in cycles after the tick edge cycle, well inside vblank.
- Mallet inputs are sampled only in the HIT cycle.
- start is ignored outside IDLE.
- A tick arriving in HIT/MOVE cannot occur (frame >> 3 cycles). No queueing is required.
- rst_n asserted mid-frame or mid-hold returns all state to reset values immediately. No pulse emerges.

Test Plan:
- Reset: rst_n low then release -> xpos_ball=384, ypos_ball=512, goal pulses 0, in_play 0; no motion until start=1 plus a tick.
- Mallet hit: puck (384,512), p1 at (374,512), radius_player=20, start, one tick -> vx=+8, vy=0; xpos_ball=392 two cycles after the tick.
- Simultaneous mallets: p1 at (374,512), p2 at (394,512), both overlapping -> player 1 priority, vx=+8.
- Wall reflect: puck x=740, vx=+8, away from goal rows -> x clamps to 738, vx=-8; next frame x=730.
- Goal: puck (384,35), vy=-8 -> goal_top high exactly one cycle. Puck holds for 60 ticks, then returns to (384,512) with zero velocity.
- Friction and reset: vx=+8 with no hits over 64 frames -> vx decrements by 1 every 8 frames to 0. Asserting rst_n mid-GOAL_HOLD gives immediate centre and IDLE.

Source files
------------

// File: rtl/puck_motion_ctl.sv
// -----------------------------------------------------------------------------
// puck_motion_ctl
// Per-frame puck physics for the air-hockey pipeline. On each frame tick (rising
// edge of vblnk_in) the puck is tested against both mallets, moved by its
// velocity, reflected off the side walls, slowed by friction and checked for
// goals. After a goal the puck is held, then re-served from the centre.
//
// Ports
//   clk_in         pixel clock
//   rst_n          asynchronous active-low reset
//   vblnk_in       vertical blank; its rising edge is the frame tick
//   start          level, serves the puck out of IDLE on a tick
//   p1_xpos/ypos   player 1 mallet centre
//   p2_xpos/ypos   player 2 mallet centre
//   radius_player  mallet radius
//   xpos_ball      puck centre x (registered)
//   ypos_ball      puck centre y (registered)
//   goal_top       one-cycle pulse, puck entered the top goal
//   goal_bottom    one-cycle pulse, puck entered the bottom goal
//   in_play        high in FRAME_WAIT / HIT / MOVE (registered)
// -----------------------------------------------------------------------------
module puck_motion_ctl #(
   parameter int unsigned X_MIN           = 32'd20,
   parameter int unsigned X_MAX           = 32'd748,
   parameter int unsigned Y_MIN           = 32'd20,
   parameter int unsigned Y_MAX           = 32'd1004,
   parameter int unsigned X_CENTRE        = 32'd384,
   parameter int unsigned Y_CENTRE        = 32'd512,
   parameter int unsigned GOAL_X_LO       = 32'd284,
   parameter int unsigned GOAL_X_HI       = 32'd484,
   parameter int unsigned RADIUS          = 32'd10,
   parameter int unsigned HIT_SPEED       = 32'd8,
   parameter int unsigned MAX_SPEED       = 32'd15,
   parameter int unsigned FRICTION_FRAMES = 32'd8,
   parameter int unsigned RESPAWN_FRAMES  = 32'd60
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        vblnk_in,
   input  logic        start,
   input  logic [11:0] p1_xpos,
   input  logic [11:0] p1_ypos,
   input  logic [11:0] p2_xpos,
   input  logic [11:0] p2_ypos,
   input  logic [7:0]  radius_player,
   output logic [11:0] xpos_ball,
   output logic [11:0] ypos_ball,
   output logic        goal_top,
   output logic        goal_bottom,
   output logic        in_play
);

   // Wall limits for the puck centre (inner wall plus/minus puck radius).
   localparam logic signed [13:0] X_LO      = 14'(X_MIN + RADIUS);
   localparam logic signed [13:0] X_HI      = 14'(X_MAX - RADIUS);
   localparam logic signed [13:0] Y_LO      = 14'(Y_MIN + RADIUS);
   localparam logic signed [13:0] Y_HI      = 14'(Y_MAX - RADIUS);
   localparam logic [11:0]        X_LO_P    = 12'(X_MIN + RADIUS);
   localparam logic [11:0]        X_HI_P    = 12'(X_MAX - RADIUS);
   localparam logic [11:0]        Y_LO_P    = 12'(Y_MIN + RADIUS);
   localparam logic [11:0]        Y_HI_P    = 12'(Y_MAX - RADIUS);
   localparam logic [11:0]        GX_LO_P   = 12'(GOAL_X_LO);
   localparam logic [11:0]        GX_HI_P   = 12'(GOAL_X_HI);
   localparam logic [11:0]        X_CEN     = 12'(X_CENTRE);
   localparam logic [11:0]        Y_CEN     = 12'(Y_CENTRE);
   localparam logic [8:0]         RAD9      = 9'(RADIUS);
   localparam logic signed [7:0]  HIT_V     = 8'(HIT_SPEED);
   localparam logic signed [8:0]  VMAX      = 9'(MAX_SPEED);
   localparam logic [7:0]         FRIC_LAST = 8'(FRICTION_FRAMES - 32'd1);
   localparam logic [7:0]         RESP_LAST = 8'(RESPAWN_FRAMES - 32'd1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FRAME_WAIT = 3'd1,
      ST_HIT        = 3'd2,
      ST_MOVE       = 3'd3,
      ST_GOAL_HOLD  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              vblnk_dly_q, vblnk_dly_d;
   logic [11:0]       xpos_q, xpos_d, ypos_q, ypos_d;
   logic signed [7:0] vx_q, vx_d, vy_q, vy_d;
   logic [7:0]        fric_cnt_q, fric_cnt_d;
   logic [7:0]        resp_cnt_q, resp_cnt_d;
   logic              goal_top_q, goal_top_d;
   logic              goal_bottom_q, goal_bottom_d;
   logic              in_play_q, in_play_d;

   logic              tick;
   logic signed [12:0] dx1, dy1, dx2, dy2;
   logic              hit1, hit2;
   logic signed [13:0] nx, ny;
   logic signed [8:0] vx_ext, vy_ext, vx_ref, vy_ref;
   logic [11:0]       x_new, y_new;
   logic              in_mouth, goal_t, goal_b;

   // Signed 13-bit difference of two unsigned 12-bit coordinates.
   function automatic logic signed [12:0] diff13(input logic [11:0] a, input logic [11:0] b);
      diff13 = $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   // Square of a 13-bit signed difference as a 26-bit unsigned value.
   function automatic logic [25:0] square13(input logic signed [12:0] d);
      logic [12:0] mag;
      mag      = d[12] ? 13'(-d) : 13'(d);
      square13 = {13'd0, mag} * {13'd0, mag};
   endfunction

   // Circle overlap: dx^2 + dy^2 <= (RADIUS + mallet radius)^2, at 27 bits.
   function automatic logic mallet_hit(input logic signed [12:0] dx,
                                       input logic signed [12:0] dy,
                                       input logic [7:0]         rp);
      logic [26:0] dist_sq;
      logic [26:0] reach_sq;
      logic [8:0]  reach;
      dist_sq    = {1'b0, square13(dx)} + {1'b0, square13(dy)};
      reach      = RAD9 + {1'b0, rp};
      reach_sq   = {18'd0, reach} * {18'd0, reach};
      mallet_hit = (dist_sq <= reach_sq);
   endfunction

   // Post-hit speed along one axis: HIT_SPEED in the direction away from the mallet.
   function automatic logic signed [7:0] hit_vel(input logic signed [12:0] d);
      if (d == 13'sd0) begin
         hit_vel = 8'sd0;
      end else if (d[12]) begin
         hit_vel = -HIT_V;
      end else begin
         hit_vel = HIT_V;
      end
   endfunction

   // Clamp a 9-bit velocity into +/-MAX_SPEED.
   function automatic logic signed [7:0] sat_vel(input logic signed [8:0] v);
      logic signed [8:0] vneg;
      vneg = -VMAX;
      if (v > VMAX) begin
         sat_vel = VMAX[7:0];
      end else if (v < vneg) begin
         sat_vel = vneg[7:0];
      end else begin
         sat_vel = v[7:0];
      end
   endfunction

   // One friction step: move a velocity one unit toward zero.
   function automatic logic signed [7:0] decay(input logic signed [7:0] v);
      if (v > 8'sd0) begin
         decay = v - 8'sd1;
      end else if (v < 8'sd0) begin
         decay = v + 8'sd1;
      end else begin
         decay = v;
      end
   endfunction

   // Frame tick detection and mallet overlap tests.
   always_comb begin
      tick        = vblnk_in & ~vblnk_dly_q;
      vblnk_dly_d = vblnk_in;
      dx1         = diff13(xpos_q, p1_xpos);
      dy1         = diff13(ypos_q, p1_ypos);
      dx2         = diff13(xpos_q, p2_xpos);
      dy2         = diff13(ypos_q, p2_ypos);
      hit1        = mallet_hit(dx1, dy1, radius_player);
      hit2        = mallet_hit(dx2, dy2, radius_player);
   end

   // Candidate position, wall reflection and goal detection for the MOVE cycle.
   always_comb begin
      vx_ext = $signed({vx_q[7], vx_q});
      vy_ext = $signed({vy_q[7], vy_q});
      nx     = $signed({2'b00, xpos_q}) + $signed({{6{vx_q[7]}}, vx_q});
      ny     = $signed({2'b00, ypos_q}) + $signed({{6{vy_q[7]}}, vy_q});
      vx_ref = vx_ext;
      vy_ref = vy_ext;
      x_new  = nx[11:0];
      y_new  = ny[11:0];
      goal_t = 1'b0;
      goal_b = 1'b0;

      if (nx < X_LO) begin
         x_new  = X_LO_P;
         vx_ref = -vx_ext;
      end else if (nx > X_HI) begin
         x_new  = X_HI_P;
         vx_ref = -vx_ext;
      end else begin
         x_new  = nx[11:0];
      end

      // Goal mouth uses the x position after the side-wall clamp.
      in_mouth = (x_new >= GX_LO_P) && (x_new <= GX_HI_P);

      if (ny < Y_LO) begin
         if (in_mouth) begin
            goal_t = 1'b1;
         end else begin
            y_new  = Y_LO_P;
            vy_ref = -vy_ext;
         end
      end else if (ny > Y_HI) begin
         if (in_mouth) begin
            goal_b = 1'b1;
         end else begin
            y_new  = Y_HI_P;
            vy_ref = -vy_ext;
         end
      end else begin
         y_new = ny[11:0];
      end
   end

   // Frame state machine: next state, kinematics and output pulses.
   always_comb begin
      state_d       = state_q;
      xpos_d        = xpos_q;
      ypos_d        = ypos_q;
      vx_d          = vx_q;
      vy_d          = vy_q;
      fric_cnt_d    = fric_cnt_q;
      resp_cnt_d    = resp_cnt_q;
      goal_top_d    = 1'b0;
      goal_bottom_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            xpos_d = X_CEN;
            ypos_d = Y_CEN;
            if (tick && start) begin
               state_d = ST_FRAME_WAIT;
               vx_d    = 8'sd0;
               vy_d    = 8'sd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FRAME_WAIT: begin
            if (tick) begin
               state_d = ST_HIT;
            end else begin
               state_d = ST_FRAME_WAIT;
            end
         end
         ST_HIT: begin
            state_d = ST_MOVE;
            // Player 1 takes priority when both mallets overlap the puck.
            if (hit1) begin
               vx_d       = hit_vel(dx1);
               vy_d       = hit_vel(dy1);
               fric_cnt_d = 8'd0;
            end else if (hit2) begin
               vx_d       = hit_vel(dx2);
               vy_d       = hit_vel(dy2);
               fric_cnt_d = 8'd0;
            end else begin
               fric_cnt_d = fric_cnt_q;
            end
         end
         ST_MOVE: begin
            if (goal_t || goal_b) begin
               // Puck freezes where it was; only the pulse and the hold start.
               goal_top_d    = goal_t;
               goal_bottom_d = goal_b;
               resp_cnt_d    = 8'd0;
               state_d       = ST_GOAL_HOLD;
            end else begin
               xpos_d  = x_new;
               ypos_d  = y_new;
               state_d = ST_FRAME_WAIT;
               if (fric_cnt_q == FRIC_LAST) begin
                  fric_cnt_d = 8'd0;
                  vx_d       = decay(sat_vel(vx_ref));
                  vy_d       = decay(sat_vel(vy_ref));
               end else begin
                  fric_cnt_d = fric_cnt_q + 8'd1;
                  vx_d       = sat_vel(vx_ref);
                  vy_d       = sat_vel(vy_ref);
               end
            end
         end
         ST_GOAL_HOLD: begin
            if (tick) begin
               if (resp_cnt_q == RESP_LAST) begin
                  xpos_d     = X_CEN;
                  ypos_d     = Y_CEN;
                  vx_d       = 8'sd0;
                  vy_d       = 8'sd0;
                  resp_cnt_d = 8'd0;
                  fric_cnt_d = 8'd0;
                  state_d    = ST_FRAME_WAIT;
               end else begin
                  resp_cnt_d = resp_cnt_q + 8'd1;
               end
            end else begin
               resp_cnt_d = resp_cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_play_d = (state_d == ST_FRAME_WAIT) || (state_d == ST_HIT) || (state_d == ST_MOVE);
   end

   // State and output registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         vblnk_dly_q   <= 1'b0;
         xpos_q        <= X_CEN;
         ypos_q        <= Y_CEN;
         vx_q          <= 8'sd0;
         vy_q          <= 8'sd0;
         fric_cnt_q    <= 8'd0;
         resp_cnt_q    <= 8'd0;
         goal_top_q    <= 1'b0;
         goal_bottom_q <= 1'b0;
         in_play_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         vblnk_dly_q   <= vblnk_dly_d;
         xpos_q        <= xpos_d;
         ypos_q        <= ypos_d;
         vx_q          <= vx_d;
         vy_q          <= vy_d;
         fric_cnt_q    <= fric_cnt_d;
         resp_cnt_q    <= resp_cnt_d;
         goal_top_q    <= goal_top_d;
         goal_bottom_q <= goal_bottom_d;
         in_play_q     <= in_play_d;
      end
   end

   assign xpos_ball   = xpos_q;
   assign ypos_ball   = ypos_q;
   assign goal_top    = goal_top_q;
   assign goal_bottom = goal_bottom_q;
   assign in_play     = in_play_q;

endmodule

// File: tb/tb_puck_motion_ctl.sv
// -----------------------------------------------------------------------------
// tb_puck_motion_ctl
// Directed stimulus with hand-computed per-frame expectations pushed into a
// queue; a monitor triggered by each frame tick pops and compares once the
// frame's update has settled.
// -----------------------------------------------------------------------------
module tb_puck_motion_ctl;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b0;
   logic        vblnk_in = 1'b0;
   logic        start = 1'b0;
   logic [11:0] p1_xpos = 12'd100;
   logic [11:0] p1_ypos = 12'd100;
   logic [11:0] p2_xpos = 12'd100;
   logic [11:0] p2_ypos = 12'd900;
   logic [7:0]  radius_player = 8'd20;
   logic [11:0] xpos_ball;
   logic [11:0] ypos_ball;
   logic        goal_top;
   logic        goal_bottom;
   logic        in_play;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic        gt;
      logic        gb;
      logic        ip;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   frame_no = 0;
   int   gt_cycles = 0;
   int   gb_cycles = 0;

   always #5 clk_in = ~clk_in;

   puck_motion_ctl dut (
      .clk_in        (clk_in),
      .rst_n         (rst_n),
      .vblnk_in      (vblnk_in),
      .start         (start),
      .p1_xpos       (p1_xpos),
      .p1_ypos       (p1_ypos),
      .p2_xpos       (p2_xpos),
      .p2_ypos       (p2_ypos),
      .radius_player (radius_player),
      .xpos_ball     (xpos_ball),
      .ypos_ball     (ypos_ball),
      .goal_top      (goal_top),
      .goal_bottom   (goal_bottom),
      .in_play       (in_play)
   );

   task automatic push(input int x, input int y, input logic gt, input logic gb, input logic ip);
      exp_t e;
      e.x  = 12'(x);
      e.y  = 12'(y);
      e.gt = gt;
      e.gb = gb;
      e.ip = ip;
      exp_q.push_back(e);
   endtask

   task automatic frame();
      @(negedge clk_in);
      vblnk_in = 1'b1;
      repeat (5) @(negedge clk_in);
      vblnk_in = 1'b0;
      repeat (4) @(negedge clk_in);
   endtask

   task automatic set_far();
      p1_xpos = 12'd100;
      p1_ypos = 12'd100;
      p2_xpos = 12'd100;
      p2_ypos = 12'd900;
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_n = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
   endtask

   task automatic check_now(input string name, input int x, input int y, input logic gt,
                            input logic gb, input logic ip);
      checks++;
      if (xpos_ball !== 12'(x) || ypos_ball !== 12'(y) || goal_top !== gt ||
          goal_bottom !== gb || in_play !== ip) begin
         errors++;
         $display("FAIL %s got x=%0d y=%0d gt=%b gb=%b ip=%b required x=%0d y=%0d gt=%b gb=%b ip=%b",
                  name, xpos_ball, ypos_ball, goal_top, goal_bottom, in_play, x, y, gt, gb, ip);
      end
   endtask

   // Serve from IDLE, chase the puck upward with player 1 and score in the top goal.
   task automatic serve_and_score();
      int py;
      start = 1'b1;
      push(384, 512, 1'b0, 1'b0, 1'b1);
      frame();
      start = 1'b0;
      py = 512;
      while (py >= 40) begin
         p1_xpos = 12'd384;
         p1_ypos = 12'(py + 10);
         py -= 8;
         push(384, py, 1'b0, 1'b0, 1'b1);
         frame();
      end
      p1_xpos = 12'd384;
      p1_ypos = 12'(py + 10);
      push(384, py, 1'b1, 1'b0, 1'b0);
      frame();
      set_far();
   endtask

   // Goal pulse widths are measured in cycles.
   always @(negedge clk_in) begin
      if (goal_top === 1'b1) gt_cycles++;
      if (goal_bottom === 1'b1) gb_cycles++;
   end

   // Monitor: settle three clocks after each tick, then compare against the queue head.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge vblnk_in);
         repeat (3) @(posedge clk_in);
         #1;
         frame_no++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame%0d unexpected_frame got x=%0d y=%0d required none",
                     frame_no, xpos_ball, ypos_ball);
         end else begin
            e = exp_q.pop_front();
            if (xpos_ball !== e.x || ypos_ball !== e.y || goal_top !== e.gt ||
                goal_bottom !== e.gb || in_play !== e.ip) begin
               errors++;
               $display("FAIL frame%0d got x=%0d y=%0d gt=%b gb=%b ip=%b required x=%0d y=%0d gt=%b gb=%b ip=%b",
                        frame_no, xpos_ball, ypos_ball, goal_top, goal_bottom, in_play,
                        e.x, e.y, e.gt, e.gb, e.ip);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int px;
      int py;
      int v;

      // Reset state, during and after reset
      repeat (3) @(negedge clk_in);
      check_now("reset_low", 384, 512, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk_in);
      check_now("reset_release", 384, 512, 1'b0, 1'b0, 1'b0);

      // Tick without start: stays idle at centre
      push(384, 512, 1'b0, 1'b0, 1'b0);
      frame();

      // Serve, then player 1 hit from the left: vx=+8
      start = 1'b1;
      push(384, 512, 1'b0, 1'b0, 1'b1);
      frame();
      start = 1'b0;
      p1_xpos = 12'd374;
      p1_ypos = 12'd512;
      push(392, 512, 1'b0, 1'b0, 1'b1);
      frame();

      // Chase right to the wall, reflect at 738, then drift back at -8
      px = 392;
      while (px <= 728) begin
         p1_xpos = 12'(px - 10);
         px += 8;
         push(px, 512, 1'b0, 1'b0, 1'b1);
         frame();
      end
      p1_xpos = 12'(px - 10);
      push(738, 512, 1'b0, 1'b0, 1'b1);
      frame();
      set_far();
      push(730, 512, 1'b0, 1'b0, 1'b1);
      frame();
      push(722, 512, 1'b0, 1'b0, 1'b1);
      frame();

      // Chase down outside the goal mouth, reflect off the bottom wall at 994
      py = 512;
      while (py <= 984) begin
         p1_xpos = 12'd722;
         p1_ypos = 12'(py - 10);
         py += 8;
         push(722, py, 1'b0, 1'b0, 1'b1);
         frame();
      end
      p1_xpos = 12'd722;
      p1_ypos = 12'(py - 10);
      push(722, 994, 1'b0, 1'b0, 1'b1);
      frame();
      set_far();
      push(722, 986, 1'b0, 1'b0, 1'b1);
      frame();
      push(722, 978, 1'b0, 1'b0, 1'b1);
      frame();

      // Both mallets overlap: player 1 wins, vx=+8
      do_reset();
      start = 1'b1;
      push(384, 512, 1'b0, 1'b0, 1'b1);
      frame();
      start = 1'b0;
      p1_xpos = 12'd374; p1_ypos = 12'd512;
      p2_xpos = 12'd394; p2_ypos = 12'd512;
      push(392, 512, 1'b0, 1'b0, 1'b1);
      frame();
      set_far();

      // Player 2 only, diagonal: vx=-8, vy=+8
      do_reset();
      start = 1'b1;
      push(384, 512, 1'b0, 1'b0, 1'b1);
      frame();
      start = 1'b0;
      p2_xpos = 12'd394; p2_ypos = 12'd500;
      push(376, 520, 1'b0, 1'b0, 1'b1);
      frame();
      set_far();
      push(368, 528, 1'b0, 1'b0, 1'b1);
      frame();

      // Top goal, 60-tick hold, re-serve from centre with zero velocity
      do_reset();
      serve_and_score();
      for (int i = 1; i <= 59; i++) begin
         push(384, 32, 1'b0, 1'b0, 1'b0);
         frame();
      end
      push(384, 512, 1'b0, 1'b0, 1'b1);
      frame();
      push(384, 512, 1'b0, 1'b0, 1'b1);
      frame();

      // Second goal, reset in the middle of the hold
      do_reset();
      serve_and_score();
      for (int i = 1; i <= 10; i++) begin
         push(384, 32, 1'b0, 1'b0, 1'b0);
         frame();
      end
      @(negedge clk_in);
      rst_n = 1'b0;
      #1;
      check_now("reset_mid_hold", 384, 512, 1'b0, 1'b0, 1'b0);
      @(negedge clk_in);
      rst_n = 1'b1;
      push(384, 512, 1'b0, 1'b0, 1'b0);
      frame();

      // Friction: one hit to +8, then speed drops by one every 8 frames to 0
      do_reset();
      start = 1'b1;
      push(384, 512, 1'b0, 1'b0, 1'b1);
      frame();
      start = 1'b0;
      px = 384;
      for (int m = 1; m <= 66; m++) begin
         if (m == 1) begin
            p1_xpos = 12'd374;
            p1_ypos = 12'd512;
         end else begin
            set_far();
         end
         v = 8 - (m - 1) / 8;
         if (v < 0) v = 0;
         px += v;
         push(px, 512, 1'b0, 1'b0, 1'b1);
         frame();
      end

      repeat (10) @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
      end
      checks++;
      if (gt_cycles != 2) begin
         errors++;
         $display("FAIL goal_top_cycles got %0d required 2", gt_cycles);
      end
      checks++;
      if (gb_cycles != 0) begin
         errors++;
         $display("FAIL goal_bottom_cycles got %0d required 0", gb_cycles);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
